alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 op1  input  32  first operand (rs1 value).
REQ-004 op2  input  32  second operand (rs2 value); used by register-register ops only.
REQ-005 imm  input  32  sign-extended immediate; used by immediate ops only.
REQ-006 is_add, is_sub, is_and, is_or, is_xor, is_slt, is_sltu, is_sll, is_srl, is_sra  input  1 each  register-register op selects.
REQ-007 is_addi, is_andi, is_ori, is_xori, is_slti, is_sltiu, is_slli, is_srli, is_srai  input  1 each  immediate op selects.
REQ-008 result  output  32  registered ALU result.
REQ-009 result_valid  output  1  high for the cycle after any op select was sampled high.

Function
REQ-010 Second operand SHALL be imm for immediate ops and op2 for register-register ops.
REQ-011 Latency SHALL be one cycle: inputs sampled at edge N appear on result after edge N.
REQ-012 add/addi SHALL compute op1 + operand, modulo 2^32; carry discarded.
REQ-013 sub SHALL compute op1 - op2, modulo 2^32.
REQ-014 and/or/xor (and immediate forms) SHALL be bitwise.
REQ-015 slt/slti SHALL yield 32'h1 if op1 < operand as signed two's complement, else 32'h0.
REQ-016 sltu/sltiu SHALL yield 32'h1 if op1 < operand unsigned, else 32'h0.
REQ-017 Shifts SHALL use only operand[4:0] as shift amount; sll/srl zero-fill, sra sign-fills from op1[31].
REQ-018 When no op select is high, result SHALL load 32'h0 and result_valid SHALL be 0.
REQ-019 When several selects are high, the first in REQ-006 then REQ-007 listing order SHALL win; no error flag.
REQ-020 Output SHALL be a pure function of the sampled inputs; no other internal state.

Reset
REQ-021 While reset is high at a rising edge, result SHALL become 32'h0 and result_valid 0, regardless of op selects.
REQ-022 Reset SHALL take priority over any op select in the same cycle; first op after reset deassertion completes normally one cycle later.
REQ-023 Before the first clock edge, output values are not required to be defined.

Structure
REQ-024 A shared package alu_pkg SHALL hold XLEN = 32, SHAMT_W = 5 and an enumerated op-code type used internally after select encoding.
REQ-025 Select flags SHALL be encoded to the enum by a combinational priority encoder inside alu.
REQ-026 One sub-module, alu_shifter (combinational sll/srl/sra on XLEN-bit data), SHALL be instantiated by alu.

Verification
REQ-027 reset=1 for one edge with is_add=1, op1=5, op2=6 -> result=0, result_valid=0.
REQ-028 reset=0, is_add=1, op1=2, op2=1 -> result=3, result_valid=1 one edge later.
REQ-029 is_addi=1, op1=1, op2=2, imm=2 -> result=3 (op2 ignored).
REQ-030 is_add, op1=32'hFFFFFFFF, op2=1 -> result=0; is_sub, op1=0, op2=1 -> 32'hFFFFFFFF.
REQ-031 is_slt op1=32'hFFFFFFFF, op2=1 -> 1; is_sltu same operands -> 0; is_sra op1=32'h80000000, op2=32'h21 -> 32'hC0000000.
REQ-032 is_add and is_sub both high, op1=4, op2=1 -> result=5; all selects low -> result=0, result_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, op-code and shift-kind enums for the ALU.
package alu_pkg;
  localparam int XLEN = 32;
  localparam int SHAMT_W = 5;
  typedef enum logic [4:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_SLLI, OP_SRLI, OP_SRAI
  } op_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_e;
  function automatic logic is_imm_op(op_e op);
    return op >= OP_ADDI;
  endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: operand, op-select and result bundle between an issuing stage and the ALU.
interface alu_if;
  import alu_pkg::*;
  logic [XLEN-1:0] op1, op2, imm;
  logic is_add, is_sub, is_and, is_or, is_xor, is_slt, is_sltu, is_sll, is_srl, is_sra;
  logic is_addi, is_andi, is_ori, is_xori, is_slti, is_sltiu, is_slli, is_srli, is_srai;
  logic [XLEN-1:0] result;
  logic result_valid;
  modport master (
    output op1, op2, imm,
    output is_add, is_sub, is_and, is_or, is_xor, is_slt, is_sltu, is_sll, is_srl, is_sra,
    output is_addi, is_andi, is_ori, is_xori, is_slti, is_sltiu, is_slli, is_srli, is_srai,
    input result, result_valid
  );
  modport slave (
    input op1, op2, imm,
    input is_add, is_sub, is_and, is_or, is_xor, is_slt, is_sltu, is_sll, is_srl, is_sra,
    input is_addi, is_andi, is_ori, is_xori, is_slti, is_sltiu, is_slli, is_srli, is_srai,
    output result, result_valid
  );
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical-left, logical-right and arithmetic-right shifter.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_e             kind_i,
  output logic [XLEN-1:0]    data_o
);
  logic [XLEN-1:0] sra;
  // Kept out of the ternary so the signed context survives and >>> sign-fills.
  assign sra = $signed(data_i) >>> shamt_i;
  assign data_o = kind_i == SH_RA ? sra : kind_i == SH_RL ? data_i >> shamt_i : data_i << shamt_i;
endmodule

// File: rtl/alu.sv
// alu: single-cycle registered integer ALU driven by one-hot-ish op selects.
module alu
  import alu_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  op_e op;
  shift_e sh_kind;
  logic [XLEN-1:0] b, sh_res, result_d, result_q;
  logic valid_d, valid_q;
  // Priority encoder: register-register selects first, then immediate selects.
  always_comb begin
    op = bus.is_add ? OP_ADD : bus.is_sub ? OP_SUB : bus.is_and ? OP_AND : bus.is_or ? OP_OR :
         bus.is_xor ? OP_XOR : bus.is_slt ? OP_SLT : bus.is_sltu ? OP_SLTU : bus.is_sll ? OP_SLL :
         bus.is_srl ? OP_SRL : bus.is_sra ? OP_SRA : bus.is_addi ? OP_ADDI : bus.is_andi ? OP_ANDI :
         bus.is_ori ? OP_ORI : bus.is_xori ? OP_XORI : bus.is_slti ? OP_SLTI :
         bus.is_sltiu ? OP_SLTIU : bus.is_slli ? OP_SLLI : bus.is_srli ? OP_SRLI :
         bus.is_srai ? OP_SRAI : OP_NONE;
  end
  assign b = is_imm_op(op) ? bus.imm : bus.op2;
  assign sh_kind = (op == OP_SRA || op == OP_SRAI) ? SH_RA :
                   (op == OP_SRL || op == OP_SRLI) ? SH_RL : SH_LL;
  alu_shifter u_shifter (
    .data_i (bus.op1),
    .shamt_i(b[SHAMT_W-1:0]),
    .kind_i (sh_kind),
    .data_o (sh_res)
  );
  always_comb begin
    case (op)
      OP_ADD, OP_ADDI:    result_d = bus.op1 + b;
      OP_SUB:             result_d = bus.op1 - b;
      OP_AND, OP_ANDI:    result_d = bus.op1 & b;
      OP_OR, OP_ORI:      result_d = bus.op1 | b;
      OP_XOR, OP_XORI:    result_d = bus.op1 ^ b;
      OP_SLT, OP_SLTI:    result_d = {{(XLEN-1){1'b0}}, $signed(bus.op1) < $signed(b)};
      OP_SLTU, OP_SLTIU:  result_d = {{(XLEN-1){1'b0}}, bus.op1 < b};
      OP_SLL, OP_SRL, OP_SRA, OP_SLLI, OP_SRLI, OP_SRAI: result_d = sh_res;
      default:            result_d = '0;
    endcase
  end
  assign valid_d = op != OP_NONE;
  always_ff @(posedge clk) begin
    result_q <= reset ? '0 : result_d;
    valid_q  <= reset ? 1'b0 : valid_d;
  end
  assign bus.result = result_q;
  assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu.
module tb_alu;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  alu_if bus();
  alu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic clr();
    {bus.is_add, bus.is_sub, bus.is_and, bus.is_or, bus.is_xor, bus.is_slt, bus.is_sltu,
     bus.is_sll, bus.is_srl, bus.is_sra} = '0;
    {bus.is_addi, bus.is_andi, bus.is_ori, bus.is_xori, bus.is_slti, bus.is_sltiu,
     bus.is_slli, bus.is_srli, bus.is_srai} = '0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.imm = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] er, input logic ev);
    checks++;
    assert (bus.result === er)
      else begin failures++; $error("FAIL %s result got=%h exp=%h", tag, bus.result, er); end
    checks++;
    assert (bus.result_valid === ev)
      else begin failures++; $error("FAIL %s valid got=%b exp=%b", tag, bus.result_valid, ev); end
  endtask
  initial begin
    clr(); reset = 1'b1; bus.is_add = 1; bus.op1 = 5; bus.op2 = 6;
    tick(); chk("reset_add", 32'h0, 1'b0);
    clr(); reset = 1'b0; bus.is_add = 1; bus.op1 = 2; bus.op2 = 1;
    tick(); chk("add", 32'd3, 1'b1);
    clr(); bus.is_addi = 1; bus.op1 = 1; bus.op2 = 2; bus.imm = 2;
    tick(); chk("addi", 32'd3, 1'b1);
    clr(); bus.is_add = 1; bus.op1 = 32'hFFFFFFFF; bus.op2 = 1;
    tick(); chk("add_wrap", 32'h0, 1'b1);
    clr(); bus.is_sub = 1; bus.op1 = 0; bus.op2 = 1;
    tick(); chk("sub_wrap", 32'hFFFFFFFF, 1'b1);
    clr(); bus.is_slt = 1; bus.op1 = 32'hFFFFFFFF; bus.op2 = 1;
    tick(); chk("slt_neg", 32'h1, 1'b1);
    clr(); bus.is_sltu = 1; bus.op1 = 32'hFFFFFFFF; bus.op2 = 1;
    tick(); chk("sltu", 32'h0, 1'b1);
    clr(); bus.is_slt = 1; bus.op1 = 1; bus.op2 = 32'hFFFFFFFF;
    tick(); chk("slt_pos", 32'h0, 1'b1);
    clr(); bus.is_sra = 1; bus.op1 = 32'h80000000; bus.op2 = 32'h21;
    tick(); chk("sra_neg", 32'hC0000000, 1'b1);
    clr(); bus.is_sra = 1; bus.op1 = 32'h40000000; bus.op2 = 1;
    tick(); chk("sra_pos", 32'h20000000, 1'b1);
    clr(); bus.is_add = 1; bus.is_sub = 1; bus.op1 = 4; bus.op2 = 1;
    tick(); chk("prio_add_sub", 32'd5, 1'b1);
    clr();
    tick(); chk("idle", 32'h0, 1'b0);
    clr(); bus.is_and = 1; bus.op1 = 32'hC; bus.op2 = 32'hA;
    tick(); chk("and", 32'h8, 1'b1);
    clr(); bus.is_or = 1; bus.op1 = 32'hC; bus.op2 = 32'hA;
    tick(); chk("or", 32'hE, 1'b1);
    clr(); bus.is_xor = 1; bus.op1 = 32'hC; bus.op2 = 32'hA;
    tick(); chk("xor", 32'h6, 1'b1);
    clr(); bus.is_sll = 1; bus.op1 = 1; bus.op2 = 32'h24;
    tick(); chk("sll", 32'h10, 1'b1);
    clr(); bus.is_srl = 1; bus.op1 = 32'h80000000; bus.op2 = 31;
    tick(); chk("srl", 32'h1, 1'b1);
    clr(); bus.is_andi = 1; bus.op1 = 32'hF0F0; bus.op2 = 32'hFFFF; bus.imm = 32'hFF;
    tick(); chk("andi", 32'hF0, 1'b1);
    clr(); bus.is_ori = 1; bus.op1 = 32'hF000; bus.imm = 32'hF;
    tick(); chk("ori", 32'hF00F, 1'b1);
    clr(); bus.is_xori = 1; bus.op1 = 32'hFF; bus.imm = 32'hF;
    tick(); chk("xori", 32'hF0, 1'b1);
    clr(); bus.is_slti = 1; bus.op1 = 32'hFFFFFFFB; bus.op2 = 0; bus.imm = 32'hFFFFFFFD;
    tick(); chk("slti", 32'h1, 1'b1);
    clr(); bus.is_sltiu = 1; bus.op1 = 5; bus.imm = 32'hFFFFFFFF;
    tick(); chk("sltiu", 32'h1, 1'b1);
    clr(); bus.is_slli = 1; bus.op1 = 1; bus.op2 = 0; bus.imm = 32'h23;
    tick(); chk("slli", 32'h8, 1'b1);
    clr(); bus.is_srli = 1; bus.op1 = 32'h80000000; bus.imm = 4;
    tick(); chk("srli", 32'h08000000, 1'b1);
    clr(); bus.is_srai = 1; bus.op1 = 32'h80000000; bus.imm = 32'hFFFFFFE4;
    tick(); chk("srai", 32'hF8000000, 1'b1);
    clr(); bus.is_sll = 1; bus.is_addi = 1; bus.op1 = 1; bus.op2 = 2; bus.imm = 5;
    tick(); chk("prio_sll_addi", 32'h4, 1'b1);
    clr(); bus.is_addi = 1; bus.is_andi = 1; bus.op1 = 6; bus.imm = 3;
    tick(); chk("prio_addi_andi", 32'd9, 1'b1);
    clr(); reset = 1'b1; bus.is_sub = 1; bus.op1 = 9; bus.op2 = 2;
    tick(); chk("reset_mid", 32'h0, 1'b0);
    reset = 1'b0;
    tick(); chk("after_reset", 32'd7, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
